// File: rtl/reg_native_arb_pkg.sv
// Shared types and constants for the two-master reg_native arbiter.
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
  localparam int CNT_W = 16;

endpackage

// File: rtl/reg_native_rr_arb.sv
// Two-input round-robin grant: on a tie the master not served last wins.
module reg_native_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    if (&req)
      grant = ~last_grant;
    else if (req[1])
      grant = 1'b1;
  end

endmodule

// File: rtl/reg_native_arbiter.sv
// Two upstream reg_native masters share one downstream slave through
// a single-outstanding IDLE/ISSUE/WAIT/RESP sequencer with ack timeout.
module reg_native_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  m0_req_vld,
  input  logic                  m0_wr_en,
  input  logic                  m0_rd_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_ack_vld,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_err,
  input  logic                  m1_req_vld,
  input  logic                  m1_wr_en,
  input  logic                  m1_rd_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_ack_vld,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_err,
  output logic                  req_vld,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  import reg_native_arb_pkg::*;

  localparam int REP = (DATA_WIDTH + 31) / 32;
  localparam logic [REP*32-1:0] ERR_WIDE = {REP{DEAD_BEEF}};
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = ERR_WIDE[DATA_WIDTH-1:0];
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t                  state;
  logic                    gnt;
  logic                    last_grant;
  logic                    win;
  logic                    any;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    done;
  logic                    fin_err;
  logic [DATA_WIDTH-1:0]   fin_data;

  reg_native_rr_arb u_rr (
    .req        ({m1_req_vld, m0_req_vld}),
    .last_grant (last_grant),
    .grant      (win),
    .any        (any)
  );

  assign busy    = (state != IDLE);
  assign cnt_nxt = cnt + CNT_W'(1);

  // A real ack always beats the timeout, even on the final wait cycle.
  always_comb begin
    done     = 1'b0;
    fin_err  = 1'b0;
    fin_data = rd_data;
    if (state == ISSUE) begin
      done = ack_vld;
    end else if (state == WAIT) begin
      if (ack_vld) begin
        done = 1'b1;
      end else if (cnt_nxt == TMO) begin
        done     = 1'b1;
        fin_data = ERR_DATA;
        fin_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      req_vld    <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      m0_ack_vld <= 1'b0;
      m0_rd_data <= '0;
      m0_err     <= 1'b0;
      m1_ack_vld <= 1'b0;
      m1_rd_data <= '0;
      m1_err     <= 1'b0;
    end else begin
      req_vld    <= 1'b0;
      m0_ack_vld <= 1'b0;
      m1_ack_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt        <= win;
            last_grant <= win;
            wr_en      <= win ? m1_wr_en   : m0_wr_en;
            rd_en      <= win ? m1_rd_en   : m0_rd_en;
            addr       <= win ? m1_addr    : m0_addr;
            wr_data    <= win ? m1_wr_data : m0_wr_data;
            req_vld    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= done ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (done)
            state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done && gnt) begin
        m1_ack_vld <= 1'b1;
        m1_rd_data <= fin_data;
        m1_err     <= fin_err;
      end
      if (done && !gnt) begin
        m0_ack_vld <= 1'b1;
        m0_rd_data <= fin_data;
        m0_err     <= fin_err;
      end
    end
  end

endmodule
